// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Holds the fetch PC and a two-entry queue of {pc, instruction} pairs that
// feeds decode through a valid/ready handshake. Instruction memory answers
// combinationally for imem_addr, so each push captures the word for the
// current PC in the same cycle.
//
// Optional build macro:
//   FETCH_MISALIGN_CHECK_EN - when defined, a PC with nonzero low bits stops
//   fetching and raises fault until a redirect to an aligned PC or a reset.
//   When undefined, the low PC bits are ignored and fault is tied low.
module fetch_unit #(
  parameter int                  PC_WIDTH          = 32,
  parameter int                  INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic                         fault
);

  logic [PC_WIDTH-1:0]          pc;
  logic [1:0]                   count;
  logic [PC_WIDTH-1:0]          head_pc;
  logic [INSTRUCTION_WIDTH-1:0] head_instruction;
  logic [PC_WIDTH-1:0]          tail_pc;
  logic [INSTRUCTION_WIDTH-1:0] tail_instruction;
  logic                         misaligned;
  logic                         pop;
  logic                         push;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;

  assign misaligned = (pc[1:0] != 2'b00);

  // Fault doubles as the halt flag: a misaligned PC never advances, so the
  // condition persists until a redirect re-evaluates it or reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= (redirect_pc[1:0] != 2'b00);
    end else if (misaligned) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  assign imem_addr       = pc;
  assign out_valid       = (count != 2'd0);
  assign out_pc          = head_pc;
  assign out_instruction = head_instruction;

  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign pop  = out_valid && out_ready;
  assign push = !redirect_valid && !misaligned && ((count != 2'd2) || pop);

  // PC: redirect target wins, otherwise advance by one word on each push.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + PC_WIDTH'(4);
    end
  end

  // Occupancy: a redirect flushes; otherwise net of one push and one pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage: head feeds decode, tail is the second-oldest entry.
  // NOTE: payload registers carry no reset; count alone says which entries
  // are meaningful, so their contents after reset never reach a consumer.
  always_ff @(posedge clk) begin
    if (pop && (count == 2'd2)) begin
      head_pc          <= tail_pc;
      head_instruction <= tail_instruction;
    end else if (push && ((count == 2'd0) || (pop && (count == 2'd1)))) begin
      head_pc          <= pc;
      head_instruction <= imem_instruction;
    end

    if (push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop))) begin
      tail_pc          <= pc;
      tail_instruction <= imem_instruction;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed table of per-cycle vectors, hand-written reset and fault
// sequences, and a randomized phase checked against a queue-based model.
// Outputs are checked and inputs driven on the falling clock edge.
module tb_fetch_unit;

  localparam int PW = 32;
  localparam int IW = 32;

  logic          clk;
  logic          rst;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_instruction;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instruction;
  logic [PW-1:0] out_pc;
  logic          fault;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(
    .PC_WIDTH(PW),
    .INSTRUCTION_WIDTH(IW),
    .RESET_PC('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a fixed scramble of the address, answered combinationally.
  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  assign imem_instruction = mem_word(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          ready;
    logic          redir;
    logic [PW-1:0] rpc;
    logic          exp_valid;
    logic [PW-1:0] exp_pc;
    logic [PW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ready, input logic redir, input logic [PW-1:0] rpc,
                              input logic exp_valid, input logic [PW-1:0] exp_pc,
                              input logic [PW-1:0] exp_addr);
    vec_t v;
    v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.exp_valid = exp_valid; v.exp_pc = exp_pc; v.exp_addr = exp_addr;
    return v;
  endfunction

  // Checks the visible outputs against an expected head entry and fetch address.
  task automatic check_state(input string tag, input logic exp_valid, input logic [PW-1:0] exp_pc,
                             input logic [PW-1:0] exp_addr, input logic exp_fault);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    check({tag, ".imem_addr"}, 64'(imem_addr), 64'(exp_addr));
    check({tag, ".fault"}, 64'(fault), 64'(exp_fault));
    if (exp_valid) begin
      check({tag, ".out_pc"}, 64'(out_pc), 64'(exp_pc));
      check({tag, ".out_instruction"}, 64'(out_instruction), 64'(mem_word(exp_pc)));
    end
  endtask

  // Reference model: a queue of fetched PCs and the next PC to fetch.
  logic [PW-1:0] model_q[$];
  logic [PW-1:0] model_pc;

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    // Reset state, held across a few clock edges.
    repeat (3) @(negedge clk);
    check_state("reset", 1'b0, '0, 32'h0, 1'b0);
    rst = 1'b0;

    // Directed per-cycle vectors starting at reset release:
    // start-up stream, stall with full queue, redirect while full,
    // PC wrap, back-to-back redirects.
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0,        32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h4,        32'h8));
    vecs.push_back(mk(0, 1, 32'h0,        1, 32'h8,        32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0,        32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h4,        32'hC));
    vecs.push_back(mk(1, 1, 32'h40,       1, 32'h8,        32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h40));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h40,       32'h44));
    vecs.push_back(mk(1, 1, 32'hFFFFFFFC, 1, 32'h44,       32'h48));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'hFFFFFFFC));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h0));
    vecs.push_back(mk(1, 1, 32'h100,      1, 32'h0,        32'h4));
    vecs.push_back(mk(1, 1, 32'h200,      0, 32'h0,        32'h100));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h200));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h200,      32'h204));
`ifndef FETCH_MISALIGN_CHECK_EN
    // Without the check, a misaligned target is fetched like any other.
    vecs.push_back(mk(1, 1, 32'h42,       1, 32'h204,      32'h208));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h42));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h42,       32'h46));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h46,       32'h4A));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                  vecs[i].exp_addr, 1'b0);
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
    end

    // Randomized phase: start from a known redirect, then follow the model.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1000;
    model_q.delete();
    model_pc = 32'h1000;
    @(negedge clk);

    for (int cyc = 0; cyc < 400; cyc++) begin
      logic popped;
      check_state($sformatf("rand%0d", cyc), model_q.size() != 0,
                  (model_q.size() != 0) ? model_q[0] : '0, model_pc, 1'b0);

      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC))
                                                   : ($urandom & 32'hFFFF_FFFC);

      // Decode consumes the head whenever it is offered and accepted;
      // a redirect discards everything and restarts at the target; otherwise
      // the current PC is fetched whenever a slot is free after the pop.
      popped = (model_q.size() != 0) && out_ready;
      if (redirect_valid) begin
        model_q.delete();
        model_pc = redirect_pc;
      end else begin
        if (popped) void'(model_q.pop_front());
        if (model_q.size() < 2) begin
          model_q.push_back(model_pc);
          model_pc = model_pc + 32'd4;
        end
      end
      @(negedge clk);
    end

    // Reset in the middle of a stream with the queue full.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_state("prereset_full", 1'b1, 32'h300, 32'h308, 1'b0);
    rst = 1'b1;
    #1;
    check_state("async_reset", 1'b0, '0, 32'h0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check_state("in_reset", 1'b0, '0, 32'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_state("restart0", 1'b1, 32'h0, 32'h4, 1'b0);
    @(negedge clk);
    check_state("restart1", 1'b1, 32'h4, 32'h8, 1'b0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts with fault; an aligned redirect recovers.
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_state("misalign0", 1'b0, '0, 32'h42, 1'b1);
    @(negedge clk);
    check_state("misalign1", 1'b0, '0, 32'h42, 1'b1);
    @(negedge clk);
    check_state("misalign2", 1'b0, '0, 32'h42, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_state("realign0", 1'b0, '0, 32'h80, 1'b0);
    @(negedge clk);
    check_state("realign1", 1'b1, 32'h80, 32'h84, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of all PC/address ports.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port imem_addr, output, PC_WIDTH: byte address to instruction memory, equal to current PC (combinational from the PC register).
REQ-007 SHALL have port imem_instruction, input, INSTRUCTION_WIDTH: word returned combinationally, same cycle, for imem_addr.
REQ-008 SHALL have port redirect_valid, input, 1: branch/jump redirect request.
REQ-009 SHALL have port redirect_pc, input, PC_WIDTH: redirect target.
REQ-010 SHALL have port out_valid, output, 1: queue head valid to decode.
REQ-011 SHALL have port out_ready, input, 1: decode accepts head.
REQ-012 SHALL have port out_instruction, output, INSTRUCTION_WIDTH: head instruction.
REQ-013 SHALL have port out_pc, output, PC_WIDTH: PC of head instruction.
REQ-014 SHALL have port fault, output, 1: misaligned-fetch fault flag (REQ-030).

Function
REQ-015 SHALL hold a PC register and a 2-entry FIFO of {pc, instruction} pairs, occupancy count 0..2.
REQ-016 Pop: SHALL occur when out_valid && out_ready; out_valid SHALL equal (count != 0).
REQ-017 Push: SHALL occur when not redirecting, not halted, and (count < 2 or pop this cycle); pushed entry = {PC, imem_instruction}; PC SHALL advance by 4 (wraps modulo 2^PC_WIDTH).
REQ-018 No push: PC SHALL hold; imem_addr SHALL remain the held PC.
REQ-019 Full with simultaneous pop: SHALL push and pop same cycle, count stays 2, order preserved.
REQ-020 Redirect: when redirect_valid=1, SHALL flush FIFO (count 0, out_valid 0 next cycle), load PC with redirect_pc, no push that cycle; pop handshake that cycle still counts as consumed.
REQ-021 Latency: first instruction at new PC SHALL appear on out_* one cycle after the PC holds it (i.e. 1 cycle after reset release or after a redirect edge).
REQ-022 out_instruction/out_pc SHALL be driven from registers only (no combinational path from imem_instruction or redirect inputs).
REQ-023 Back-to-back redirects: last one SHALL win; each flushes.
REQ-024 Throughput: with out_ready held 1, SHALL deliver one instruction per cycle, sequential PCs.

Reset
REQ-025 On rst=1, asynchronously: PC=RESET_PC, count=0, out_valid=0, fault=0, halt cleared; FIFO data contents don't-care.
REQ-026 Reset mid-operation SHALL discard all queued entries; no pop occurs during reset.
REQ-027 First push SHALL occur on the first rising clk edge with rst=0.

Configuration
REQ-028 Macro FETCH_MISALIGN_CHECK_EN SHALL select misaligned-PC checking.
REQ-029 Without it: PC[1:0] SHALL be ignored, fetch proceeds, fault tied 0.
REQ-030 With it: if PC[1:0] != 0 (after reset or redirect), SHALL not push, SHALL set fault=1 and halt; fault and halt held until next redirect to an aligned PC or reset; queued entries still drain.

Verification
REQ-031 Reset release, RESET_PC=0, out_ready=1 -> out_pc 0x0,0x4,0x8 on cycles 1,2,3 with matching memory words.
REQ-032 out_ready=0 for 5 cycles -> count saturates at 2, PC holds 0x8, out_pc stays 0x0; out_ready=1 -> 0x0,0x4,0x8 delivered in order, no gaps.
REQ-033 Redirect to 0x40 while FIFO full -> next cycle out_valid=0, following cycle out_pc=0x40, then 0x44.
REQ-034 rst asserted with FIFO full mid-stream -> out_valid=0 immediately; after release out_pc restarts at RESET_PC.
REQ-035 With FETCH_MISALIGN_CHECK_EN, redirect to 0x42 -> fault=1 next cycle, no new entries; redirect to 0x80 -> fault=0, out_pc=0x80.
REQ-036 PC=0xFFFFFFFC, out_ready=1 -> out_pc 0xFFFFFFFC then 0x00000000.
